// File: rtl/rv_ctrl_pkg.sv
// Shared encodings and the per-stage control bundle for the RV32I pipeline control unit.
package rv_ctrl_pkg;

  // Major opcodes, keyed on inst[6:2].
  localparam logic [4:0] OPC_LOAD   = 5'd0;
  localparam logic [4:0] OPC_OP_IMM = 5'd4;
  localparam logic [4:0] OPC_AUIPC  = 5'd5;
  localparam logic [4:0] OPC_STORE  = 5'd8;
  localparam logic [4:0] OPC_OP     = 5'd12;
  localparam logic [4:0] OPC_LUI    = 5'd13;
  localparam logic [4:0] OPC_BRANCH = 5'd24;
  localparam logic [4:0] OPC_JALR   = 5'd25;
  localparam logic [4:0] OPC_JAL    = 5'd27;

  localparam logic [2:0] F3_SHIFT_RIGHT = 3'b101;

  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b0011;

  typedef enum logic [2:0] {
    IMM_S = 3'b000,
    IMM_J = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_I = 3'b100
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_sel;
    logic       asel;
    logic       bsel;
    logic [2:0] br_type;
    logic       is_branch;
    logic       is_jump;
    logic       is_load;
    logic       mem_rw;
    logic [2:0] size;
    logic       reg_wen;
    wb_sel_e    wb_sel;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  function automatic logic [3:0] alu_op(input logic [2:0] funct3, input logic funct7_b5);
    return {funct3, funct7_b5};
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use / RAW interlock, redirect flush and EX-stage forwarding selects.
module hazard_unit
  import rv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic                  rst,
  input  logic                  stall_ext,
  input  logic                  ex_br_taken,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic                  ex_is_jump,
  input  logic                  ex_is_load,
  input  logic                  ex_reg_wen,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic                  exmem_reg_wen,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  memwb_reg_wen,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  output logic                  pc_sel,
  output logic                  pc_stall,
  output logic                  ifid_stall,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
);

  function automatic logic hit(input logic wen, input logic [REG_ADDR_W-1:0] rd,
                               input logic [REG_ADDR_W-1:0] src);
    return wen && (rd != '0) && (rd == src);
  endfunction

  logic redirect, load_use, raw, hazard;

  always_comb begin
    redirect = ~rst & ex_valid & (ex_is_jump | (ex_is_branch & ex_br_taken)) & ~stall_ext;
    load_use = ex_is_load & (hit(ex_reg_wen, ex_rd, id_rs1) | hit(ex_reg_wen, ex_rd, id_rs2));
    // Without forwarding any in-flight writer ahead of WB must drain first; WB itself is write-first.
    if (ENABLE_FWD)
      raw = load_use;
    else
      raw = hit(ex_reg_wen, ex_rd, id_rs1) | hit(ex_reg_wen, ex_rd, id_rs2) |
            hit(exmem_reg_wen, exmem_rd, id_rs1) | hit(exmem_reg_wen, exmem_rd, id_rs2);
    // A redirect kills the ID instruction, so its dependency no longer matters.
    hazard      = ~rst & raw & ~redirect;
    pc_sel      = redirect;
    ifid_flush  = redirect;
    pc_stall    = (~rst & stall_ext) | hazard;
    ifid_stall  = (~rst & stall_ext) | hazard;
    idex_bubble = redirect | hazard;

    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (ENABLE_FWD) begin
      if (hit(exmem_reg_wen, exmem_rd, ex_rs1))      fwd_a_sel = FWD_EXMEM;
      else if (hit(memwb_reg_wen, memwb_rd, ex_rs1)) fwd_a_sel = FWD_MEMWB;
      if (hit(exmem_reg_wen, exmem_rd, ex_rs2))      fwd_b_sel = FWD_EXMEM;
      else if (hit(memwb_reg_wen, memwb_rd, ex_rs2)) fwd_b_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// Decode and hazard control for a 5-stage RV32I pipeline; owns the ID/EX, EX/MEM and MEM/WB control registers.
module pipelined_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter bit ENABLE_FWD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_br_taken,
  input  logic        stall_ext,
  output logic [2:0]  id_imm_sel,
  output logic [3:0]  ex_alu_sel,
  output logic        ex_asel,
  output logic        ex_bsel,
  output logic [2:0]  ex_br_type,
  output logic        ex_is_branch,
  output logic        ex_is_jump,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        mem_mem_rw,
  output logic [2:0]  mem_size,
  output logic        wb_reg_wen,
  output logic [1:0]  wb_wb_sel,
  output logic        pc_sel,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        ifid_flush
);

  localparam int AW = REG_ADDR_W;

  logic [4:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_b5;
  logic [AW-1:0] id_rd, id_rs1, id_rs2;
  logic          use_rs1, use_rs2, legal;
  imm_sel_e      imm_sel;
  ctrl_bundle_t  id_ctrl;

  assign opcode    = id_inst[6:2];
  assign funct3    = id_inst[14:12];
  assign funct7_b5 = id_inst[30];
  assign id_rd     = id_inst[7 +: AW];

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path through the case can infer a latch.
    id_ctrl = CTRL_BUBBLE;
    imm_sel = IMM_I;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OPC_OP: begin
        id_ctrl.alu_sel = alu_op(funct3, funct7_b5);
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_ALU;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only shift-right immediates carry an opcode bit in funct7 (srli vs srai).
        id_ctrl.alu_sel = alu_op(funct3, (funct3 == F3_SHIFT_RIGHT) ? funct7_b5 : 1'b0);
        id_ctrl.bsel    = 1'b1;
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_ALU;
        use_rs1 = 1'b1;
      end
      OPC_LOAD: begin
        id_ctrl.alu_sel = ALU_ADD;
        id_ctrl.bsel    = 1'b1;
        id_ctrl.is_load = 1'b1;
        id_ctrl.size    = funct3;
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_MEM;
        use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        id_ctrl.alu_sel = ALU_ADD;
        id_ctrl.bsel    = 1'b1;
        id_ctrl.mem_rw  = 1'b1;
        id_ctrl.size    = funct3;
        id_ctrl.wb_sel  = WB_ALU;
        imm_sel = IMM_S;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        id_ctrl.alu_sel   = ALU_ADD;
        id_ctrl.asel      = 1'b1;
        id_ctrl.bsel      = 1'b1;
        id_ctrl.br_type   = funct3;
        id_ctrl.is_branch = 1'b1;
        id_ctrl.wb_sel    = WB_ALU;
        imm_sel = IMM_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OPC_JAL: begin
        id_ctrl.alu_sel = ALU_ADD;
        id_ctrl.asel    = 1'b1;
        id_ctrl.bsel    = 1'b1;
        id_ctrl.is_jump = 1'b1;
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_PC4;
        imm_sel = IMM_J;
      end
      OPC_JALR: begin
        id_ctrl.alu_sel = ALU_ADD;
        id_ctrl.bsel    = 1'b1;
        id_ctrl.is_jump = 1'b1;
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_PC4;
        use_rs1 = 1'b1;
      end
      OPC_LUI: begin
        id_ctrl.alu_sel = ALU_PASS_B;
        id_ctrl.bsel    = 1'b1;
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_ALU;
        imm_sel = IMM_U;
      end
      OPC_AUIPC: begin
        id_ctrl.alu_sel = ALU_ADD;
        id_ctrl.asel    = 1'b1;
        id_ctrl.bsel    = 1'b1;
        id_ctrl.reg_wen = 1'b1;
        id_ctrl.wb_sel  = WB_ALU;
        imm_sel = IMM_U;
      end
      default: legal = 1'b0;
    endcase

    if (!(id_valid && legal)) begin
      id_ctrl = CTRL_BUBBLE;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end else begin
      id_ctrl.valid = 1'b1;
      if (id_rd == '0) id_ctrl.reg_wen = 1'b0;
    end
  end

  // Unused source fields read as x0 so they can never match a producer.
  assign id_rs1     = use_rs1 ? id_inst[15 +: AW] : '0;
  assign id_rs2     = use_rs2 ? id_inst[20 +: AW] : '0;
  assign id_imm_sel = imm_sel;

  ctrl_bundle_t  ex_q, mem_q, wb_q;
  logic [AW-1:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic          idex_bubble;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every stage capture its predecessor's pre-edge value.
    if (rst) begin
      ex_q   <= CTRL_BUBBLE;
      mem_q  <= CTRL_BUBBLE;
      wb_q   <= CTRL_BUBBLE;
      ex_rd  <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
      mem_rd <= '0;
      wb_rd  <= '0;
    end else if (!stall_ext) begin
      mem_q  <= ex_q;
      mem_rd <= ex_rd;
      wb_q   <= mem_q;
      wb_rd  <= mem_rd;
      if (idex_bubble) begin
        ex_q   <= CTRL_BUBBLE;
        ex_rd  <= '0;
        ex_rs1 <= '0;
        ex_rs2 <= '0;
      end else begin
        ex_q   <= id_ctrl;
        ex_rd  <= id_rd;
        ex_rs1 <= id_rs1;
        ex_rs2 <= id_rs2;
      end
    end
  end

  hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W),
    .ENABLE_FWD(ENABLE_FWD)
  ) u_hazard (
    .rst          (rst),
    .stall_ext    (stall_ext),
    .ex_br_taken  (ex_br_taken),
    .ex_valid     (ex_q.valid),
    .ex_is_branch (ex_q.is_branch),
    .ex_is_jump   (ex_q.is_jump),
    .ex_is_load   (ex_q.is_load),
    .ex_reg_wen   (ex_q.reg_wen),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .exmem_reg_wen(mem_q.reg_wen),
    .exmem_rd     (mem_rd),
    .memwb_reg_wen(wb_q.reg_wen),
    .memwb_rd     (wb_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .pc_sel       (pc_sel),
    .pc_stall     (pc_stall),
    .ifid_stall   (ifid_stall),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
  );

  assign ex_alu_sel   = ex_q.alu_sel;
  assign ex_asel      = ex_q.asel;
  assign ex_bsel      = ex_q.bsel;
  assign ex_br_type   = ex_q.br_type;
  assign ex_is_branch = ex_q.is_branch;
  assign ex_is_jump   = ex_q.is_jump;
  assign mem_mem_rw   = mem_q.mem_rw;
  assign mem_size     = mem_q.size;
  assign wb_reg_wen   = wb_q.reg_wen;
  assign wb_wb_sel    = wb_q.wb_sel;

  logic unused_bits;
  assign unused_bits = ^{wb_q, id_inst[31], id_inst[29:25], id_inst[1:0]};

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench: a scoreboard queue tracks the expected bundle in EX, MEM and WB; hazard outputs checked per step.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        rst, id_valid, ex_br_taken, stall_ext;
  logic [31:0] id_inst;
  logic [2:0]  id_imm_sel, ex_br_type, mem_size;
  logic [3:0]  ex_alu_sel;
  logic        ex_asel, ex_bsel, ex_is_branch, ex_is_jump, mem_mem_rw, wb_reg_wen;
  logic [1:0]  fwd_a_sel, fwd_b_sel, wb_wb_sel;
  logic        pc_sel, pc_stall, ifid_stall, ifid_flush;

  pipelined_control_unit dut (
    .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
    .ex_br_taken(ex_br_taken), .stall_ext(stall_ext), .id_imm_sel(id_imm_sel),
    .ex_alu_sel(ex_alu_sel), .ex_asel(ex_asel), .ex_bsel(ex_bsel), .ex_br_type(ex_br_type),
    .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .mem_mem_rw(mem_mem_rw), .mem_size(mem_size),
    .wb_reg_wen(wb_reg_wen), .wb_wb_sel(wb_wb_sel), .pc_sel(pc_sel), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] alu;
    logic       asel;
    logic       bsel;
    logic [2:0] br;
    logic       isb;
    logic       isj;
    logic       rw;
    logic [2:0] size;
    logic       wen;
    logic [1:0] wb;
  } exp_t;

  localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  int    n_checks = 0;
  int    n_fail   = 0;
  string step_name = "reset";
  exp_t  sb_q[$];
  exp_t  bub = '0;

  function automatic exp_t mk(logic [3:0] alu, logic asel, logic bsel, logic [2:0] br, logic isb,
                              logic isj, logic rw, logic [2:0] size, logic wen, logic [1:0] wb);
    exp_t e;
    e = {alu, asel, bsel, br, isb, isj, rw, size, wen, wb};
    return e;
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [6:0] op);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", step_name, tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input logic e_pc_sel, input logic e_stall, input logic e_flush);
    chk("pc_sel", 32'(pc_sel), 32'(e_pc_sel));
    chk("pc_stall", 32'(pc_stall), 32'(e_stall));
    chk("ifid_stall", 32'(ifid_stall), 32'(e_stall));
    chk("ifid_flush", 32'(ifid_flush), 32'(e_flush));
  endtask

  task automatic chk_fwd(input logic [1:0] a, input logic [1:0] b);
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(a));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(b));
  endtask

  task automatic check_stages();
    exp_t e, m, w;
    e = sb_q[2];
    m = sb_q[1];
    w = sb_q[0];
    chk("ex_alu_sel", 32'(ex_alu_sel), 32'(e.alu));
    chk("ex_asel", 32'(ex_asel), 32'(e.asel));
    chk("ex_bsel", 32'(ex_bsel), 32'(e.bsel));
    chk("ex_br_type", 32'(ex_br_type), 32'(e.br));
    chk("ex_is_branch", 32'(ex_is_branch), 32'(e.isb));
    chk("ex_is_jump", 32'(ex_is_jump), 32'(e.isj));
    chk("mem_mem_rw", 32'(mem_mem_rw), 32'(m.rw));
    chk("mem_size", 32'(mem_size), 32'(m.size));
    chk("wb_reg_wen", 32'(wb_reg_wen), 32'(w.wen));
    chk("wb_wb_sel", 32'(wb_wb_sel), 32'(w.wb));
  endtask

  task automatic drive(input string name, input logic [31:0] inst, input logic v,
                       input logic taken, input logic sx);
    step_name   = name;
    id_inst     = inst;
    id_valid    = v;
    ex_br_taken = taken;
    stall_ext   = sx;
    #1;
  endtask

  // enter: the bundle expected to land in ID/EX at this edge (ignored while frozen).
  task automatic clock(input exp_t enter);
    @(posedge clk);
    #1;
    if (rst) begin
      sb_q.delete();
      repeat (3) sb_q.push_back(bub);
    end else if (!stall_ext) begin
      sb_q.push_back(enter);
      void'(sb_q.pop_front());
    end
    check_stages();
  endtask

  initial begin
    logic [31:0] i_add3, i_sub4, i_lw5, i_add6, i_beq, i_addi9, i_sw, i_srai, i_jal;
    logic [31:0] i_lui7, i_bad, i_lui0, i_auipc, i_jalr, i_bge;
    exp_t e_add, e_sub, e_lw, e_beq, e_sw, e_srai, e_jal, e_lui7, e_lui0, e_auipc, e_jalr, e_bge;

    i_add3  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP);
    i_sub4  = enc_r(7'h20, 5'd1, 5'd3, 3'b000, 5'd4, OP);
    i_lw5   = enc_i(12'd0, 5'd1, 3'b010, 5'd5, LOAD);
    i_add6  = enc_r(7'h00, 5'd2, 5'd5, 3'b000, 5'd6, OP);
    i_beq   = enc_b(13'd8, 5'd2, 5'd1, 3'b000, BRANCH);
    i_addi9 = enc_i(12'd1, 5'd0, 3'b000, 5'd9, OPIMM);
    i_sw    = enc_s(12'd4, 5'd2, 5'd1, 3'b010, STORE);
    i_srai  = enc_i(12'h403, 5'd2, 3'b101, 5'd10, OPIMM);
    i_jal   = {20'h01000, 5'd1, JAL};
    i_lui7  = {20'h12345, 5'd7, LUI};
    i_bad   = 32'h0000007F;
    i_lui0  = {20'h12345, 5'd0, LUI};
    i_auipc = {20'h00001, 5'd8, AUIPC};
    i_jalr  = enc_i(12'd0, 5'd5, 3'b000, 5'd1, JALR);
    i_bge   = enc_b(13'd8, 5'd4, 5'd3, 3'b101, BRANCH);

    //          alu      asel  bsel  br      isb   isj   rw    size    wen   wb
    e_add   = mk(4'b0000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b01);
    e_sub   = mk(4'b0001, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b01);
    e_lw    = mk(4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 2'b00);
    e_beq   = mk(4'b0000, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01);
    e_sw    = mk(4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 2'b01);
    e_srai  = mk(4'b1011, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b01);
    e_jal   = mk(4'b0000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 2'b10);
    e_lui7  = mk(4'b0011, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b01);
    e_lui0  = mk(4'b0011, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01);
    e_auipc = mk(4'b0000, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 2'b01);
    e_jalr  = mk(4'b0000, 1'b0, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 2'b10);
    e_bge   = mk(4'b0000, 1'b1, 1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 2'b01);

    rst = 1'b1;
    drive("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    clock(bub);
    clock(bub);
    chk_ctl(1'b0, 1'b0, 1'b0);
    chk_fwd(2'b00, 2'b00);
    rst = 1'b0;

    // EX/MEM forwarding, no stall.
    drive("add_x3", i_add3, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_add);
    drive("sub_x4", i_sub4, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_sub);
    chk_fwd(2'b01, 2'b00);

    // Load-use: one stall cycle, then MEM/WB forwarding.
    drive("lw_x5", i_lw5, 1'b1, 1'b0, 1'b0);
    chk("imm_lw", 32'(id_imm_sel), 32'd4);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_lw);
    drive("loaduse", i_add6, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b0, 1'b1, 1'b0);
    clock(bub);
    drive("add_x6", i_add6, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_add);
    chk_fwd(2'b10, 2'b00);

    // Taken branch flushes the younger instruction.
    drive("beq", i_beq, 1'b1, 1'b0, 1'b0);
    chk("imm_beq", 32'(id_imm_sel), 32'd2);
    clock(e_beq);
    drive("beq_taken", i_addi9, 1'b1, 1'b1, 1'b0);
    chk_ctl(1'b1, 1'b0, 1'b1);
    clock(bub);

    // Store frozen in MEM by stall_ext.
    drive("sw", i_sw, 1'b1, 1'b1, 1'b0);
    chk("imm_sw", 32'(id_imm_sel), 32'd0);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_sw);
    drive("srai", i_srai, 1'b1, 1'b0, 1'b0);
    clock(e_srai);
    for (int k = 0; k < 3; k++) begin
      drive("stall_ext", i_jal, 1'b1, 1'b0, 1'b1);
      chk_ctl(1'b0, 1'b1, 1'b0);
      clock(e_jal);
    end
    drive("jal", i_jal, 1'b1, 1'b0, 1'b0);
    chk("imm_jal", 32'(id_imm_sel), 32'd1);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_jal);

    // Redirect pending under stall_ext fires once the stall drops.
    drive("jal_frozen", i_lui7, 1'b1, 1'b0, 1'b1);
    chk_ctl(1'b0, 1'b1, 1'b0);
    clock(bub);
    drive("jal_redir", i_lui7, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b1, 1'b0, 1'b1);
    clock(bub);

    // Not-taken branch, lui/auipc, illegal opcode, rd=x0, jalr, id_valid=0.
    drive("bge", i_bge, 1'b1, 1'b0, 1'b0);
    clock(e_bge);
    drive("lui_x7", i_lui7, 1'b1, 1'b0, 1'b0);
    chk("imm_lui", 32'(id_imm_sel), 32'd3);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(e_lui7);
    drive("illegal", i_bad, 1'b1, 1'b0, 1'b0);
    clock(bub);
    drive("lui_x0", i_lui0, 1'b1, 1'b0, 1'b0);
    clock(e_lui0);
    drive("auipc", i_auipc, 1'b1, 1'b0, 1'b0);
    chk("imm_auipc", 32'(id_imm_sel), 32'd3);
    clock(e_auipc);
    drive("jalr", i_jalr, 1'b1, 1'b0, 1'b0);
    chk("imm_jalr", 32'(id_imm_sel), 32'd4);
    clock(e_jalr);
    drive("jalr_redir", i_add3, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b1, 1'b0, 1'b1);
    clock(bub);
    drive("not_valid", i_add3, 1'b0, 1'b0, 1'b0);
    clock(bub);
    drive("drain", 32'h0, 1'b0, 1'b0, 1'b0);
    clock(bub);

    // Reset with a store in MEM and a jal in EX.
    drive("sw2", i_sw, 1'b1, 1'b0, 1'b0);
    clock(e_sw);
    drive("jal2", i_jal, 1'b1, 1'b0, 1'b0);
    clock(e_jal);
    rst = 1'b1;
    drive("mid_reset", i_addi9, 1'b1, 1'b0, 1'b0);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(bub);
    chk_ctl(1'b0, 1'b0, 1'b0);
    chk_fwd(2'b00, 2'b00);
    rst = 1'b0;
    drive("post_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    chk_ctl(1'b0, 1'b0, 1'b0);
    clock(bub);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
